pipe_skid_buf: RTL and testbench
================================

Name: pipe_skid_buf

Overview:
- Two-entry valid/ready skid buffer placed between processor pipeline stages, e.g. IF to ID and ID to EX.
- Fills the consumer side of a plain stage register: it accepts a payload from the upstream stage and holds it until the downstream stage takes it.
- Supports back-pressure and flush.
- in_ready is a registered function of buffer state, so no combinational path runs from out_ready to in_ready.

Parameters:
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous pipeline flush (branch/jump redirect).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  buffer can accept a payload this cycle.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  payload available to downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_WIDTH  payload to downstream.
- stall_cnt  output  32  present only with PIPE_SKID_STALL_CNT_EN (see Optional Feature).

Behaviour:
- Storage: main register (main_q, main_v) and skid register (skid_q, skid_v).
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Output mapping: out_valid = main_v; out_data = main_q; in_ready = !skid_v. All three depend only on registers.
- Reset (async, rst=1): state EMPTY; main_q, skid_q = 0; main_v, skid_v = 0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1.
- States are encoded by (main_v, skid_v): EMPTY=00, BUSY=10, FULL=11. Code 01 is illegal and never reachable.
- EMPTY:
  - in_fire: main_q<=in_data, go BUSY.
  - otherwise: stay.
  - out_ready is ignored.
- BUSY:
  - in_fire & out_fire: main_q<=in_data, stay BUSY. Sustains 1 payload/cycle.
  - in_fire only: skid_q<=in_data, go FULL.
  - out_fire only: go EMPTY.
  - neither: hold.
- FULL:
  - in_ready=0, so in_valid is ignored.
  - out_fire: main_q<=skid_q, go BUSY.
  - otherwise: hold both entries.
- Latency: a payload accepted in cycle N is visible on out_* in cycle N+1. There is no combinational in-to-out path.
- Ordering: strict FIFO. The skid entry is never emitted before the main entry.
- Flush:
  - Synchronous; highest priority over all fire events in the same cycle.
  - Next state EMPTY: main_v, skid_v <= 0. A payload offered in the flush cycle is dropped.
  - out_fire in the flush cycle still counts as consumed by downstream; the buffer does not re-present it.
  - Data registers are not cleared by flush.
- Reset mid-operation: immediate clear to EMPTY regardless of clk. Pending entries are lost.
- Data registers load only on the transitions listed above, via enable; they hold otherwise.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[31:0], which counts cycles with out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst, not by flush.
  - Increments in a flush cycle if the stall condition holds.
- When undefined: port and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - localparams ST_EMPTY=2'b00, ST_BUSY=2'b10, ST_FULL=2'b11.
  - STALL_CNT_W=32.
- Sub-module en_ff #(DATA_WIDTH):
  - Load-enabled register with async active-high reset to 0.
  - Ports clk, rst, en, din, dout.
  - Instantiated twice, for main_q and skid_q.
- Valid bits and next-state logic live in pipe_skid_buf.

Test Plan:
- Reset: assert rst mid-cycle with both entries full → out_valid=0, out_data=0, in_ready=1 immediately, without waiting for a clk edge.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on cycles N+1..N+3; in_ready stays 1.
- Back-pressure:
  - out_ready=0, push 0xA0 then 0xA1 → FULL; in_ready=0; third in_valid with 0xA2 is ignored.
  - Then out_ready=1 → outputs 0xA0, then 0xA1; no 0xA2.
- Flush: FULL with 0xB0/0xB1, assert flush with in_valid=1 and in_data=0xB2 → next cycle out_valid=0, in_ready=1; 0xB2 never appears on out_data.
- Simultaneous in/out fire in BUSY holding 0xC0, push 0xC1 with out_ready=1 → 0xC0 consumed; out_data=0xC1 next cycle; skid_v stays 0.
- PIPE_SKID_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles, then flush → stall_cnt=5; stays 5 after flush; returns 0 only on rst.

Source files
------------

// File: rtl/pipe_skid_buf_pkg.sv
// Shared types for the pipeline skid buffer: state encoding and stall counter width.
// State codes are the concatenation {main_v, skid_v}; code 2'b01 is unreachable.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_skid_buf_en_ff.sv
// Load-enabled register with asynchronous active-high reset to zero.
module en_ff #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer between pipeline stages; in_ready is registered.
// Optional stall cycle counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_e                state_q, state_d;
  logic                  main_v, skid_v;
  logic                  in_fire, out_fire;
  logic                  main_en, skid_en, main_sel_skid;
  logic [DATA_WIDTH-1:0] main_q, skid_q, main_d;

  // Valid bits are the state encoding itself.
  assign main_v   = state_q[1];
  assign skid_v   = state_q[0];
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything and also blocks data loads, so a dropped
    // payload never shows up on out_data.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    out_valid = main_v;
    out_data  = main_q;
    in_ready  = !skid_v;
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  en_ff #(.DATA_WIDTH(DATA_WIDTH)) u_main_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (main_en),
    .din  (main_d),
    .dout (main_q)
  );

  en_ff #(.DATA_WIDTH(DATA_WIDTH)) u_skid_ff (
    .clk  (clk),
    .rst  (rst),
    .en   (skid_en),
    .din  (in_data),
    .dout (skid_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed, table-driven bench for pipe_skid_buf, plus reset and stall counter sequences.
module tb_pipe_skid_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_skid_buf #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] d, logic ordy,
                              logic eov, logic [31:0] eod, logic eir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    drive(fl, iv, d, ordy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each record: inputs held for one cycle, then outputs expected after that edge.
    // streaming
    vecs[0]  = mk(0, 1, 32'h11, 1, 1, 32'h11, 1);
    vecs[1]  = mk(0, 1, 32'h22, 1, 1, 32'h22, 1);
    vecs[2]  = mk(0, 1, 32'h33, 1, 1, 32'h33, 1);
    vecs[3]  = mk(0, 0, 32'h00, 1, 0, 32'h33, 1);
    // back-pressure: A2 offered while FULL must be ignored
    vecs[4]  = mk(0, 1, 32'hA0, 0, 1, 32'hA0, 1);
    vecs[5]  = mk(0, 1, 32'hA1, 0, 1, 32'hA0, 0);
    vecs[6]  = mk(0, 1, 32'hA2, 0, 1, 32'hA0, 0);
    vecs[7]  = mk(0, 0, 32'h00, 1, 1, 32'hA1, 1);
    vecs[8]  = mk(0, 0, 32'h00, 1, 0, 32'hA1, 1);
    // flush from FULL with a payload offered
    vecs[9]  = mk(0, 1, 32'hB0, 0, 1, 32'hB0, 1);
    vecs[10] = mk(0, 1, 32'hB1, 0, 1, 32'hB0, 0);
    vecs[11] = mk(1, 1, 32'hB2, 0, 0, 32'hB0, 1);
    vecs[12] = mk(0, 0, 32'h00, 1, 0, 32'hB0, 1);
    // simultaneous in/out fire in BUSY
    vecs[13] = mk(0, 1, 32'hC0, 0, 1, 32'hC0, 1);
    vecs[14] = mk(0, 1, 32'hC1, 1, 1, 32'hC1, 1);
    vecs[15] = mk(0, 0, 32'h00, 0, 1, 32'hC1, 1);
    vecs[16] = mk(0, 0, 32'h00, 1, 0, 32'hC1, 1);
    // flush coinciding with out_fire: entry is not re-presented
    vecs[17] = mk(0, 1, 32'hD0, 0, 1, 32'hD0, 1);
    vecs[18] = mk(1, 0, 32'h00, 1, 0, 32'hD0, 1);
    vecs[19] = mk(0, 0, 32'h00, 1, 0, 32'hD0, 1);

    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    #12;
    chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("v%0d.out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
      chk($sformatf("v%0d.out_data", i), out_data, vecs[i].eod);
      chk($sformatf("v%0d.in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
    end

    // Asynchronous reset mid-cycle with both entries occupied.
    step(0, 1, 32'hE0, 0);
    step(0, 1, 32'hE1, 0);
    chk("arst.pre_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst.out_data", out_data, 32'h0);
    chk("arst.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 32'h0, 1);
    chk("arst.after_out_valid", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STALL_CNT_EN
    chk("stall.reset", stall_cnt, 32'd0);
    step(0, 1, 32'hF0, 0);
    chk("stall.after_push", stall_cnt, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 32'h0, 0);
      chk($sformatf("stall.cnt%0d", k), stall_cnt, k);
    end
    step(1, 0, 32'h0, 1);
    chk("stall.flush", stall_cnt, 32'd5);
    chk("stall.flush_ov", {31'b0, out_valid}, 32'd0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    chk("stall.hold", stall_cnt, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("stall.rst", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
